// File: rtl/fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fetch_unit                                                 |
// | Description : Instruction fetch front end. Holds the PC, issues          |
// |               single-outstanding reads to instruction memory, buffers    |
// |               returned words in a 2-entry {instr, pc} FIFO and presents  |
// |               the FIFO head to decode with a valid/ready handshake.      |
// |               Branch redirects flush the FIFO and, if a read is still    |
// |               in flight, wait for its ack and drop the returned data.    |
// | Options     : `define FETCH_PERF_CNT_EN adds the perf_fetched and        |
// |               perf_flushes counter outputs.                              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [3:0]  cond,
  output logic [1:0]  op,
  output logic [5:0]  func,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] perf_fetched,
  output logic [15:0] perf_flushes,
`endif
  output logic [3:0]  rd
);

  // FSM encoding: FETCH issues new reads, WAIT holds an unacked read,
  // DISCARD holds an unacked read whose data must be thrown away.
  localparam logic [1:0] S_FETCH   = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_DISCARD = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  // Address of the read being drained in DISCARD; pc_q already holds the
  // redirect target by then, so the two must be kept separately.
  logic [31:0] hold_addr_q, hold_addr_d;

  logic [31:0] fifo_instr_q [2];
  logic [31:0] fifo_pc_q    [2];
  logic        rd_ptr_q;
  logic        wr_ptr_q;
  logic [1:0]  count_q, count_d;

  logic        push;
  logic        pop;

  // Request generation: a new read is only started when the FIFO has room,
  // while an issued read stays asserted until it is acked.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc_q;
    if (!rst) begin
      case (state_q)
        S_FETCH:   imem_req = (count_q != 2'd2);
        S_WAIT:    imem_req = 1'b1;
        S_DISCARD: imem_req = 1'b1;
        default:   imem_req = 1'b0;
      endcase
    end
    if (state_q == S_DISCARD) begin
      imem_addr = hold_addr_q;
    end
  end

  assign push        = imem_req & imem_ack & (state_q != S_DISCARD) & ~redirect;
  assign instr_valid = ~rst & (count_q != 2'd0);
  assign pop         = instr_valid & instr_ready & ~redirect;

  // Next PC / FSM: redirect overrides everything; an in-flight read that is
  // not acked in the redirect cycle must still be drained in DISCARD.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    hold_addr_d = hold_addr_q;
    case (state_q)
      S_FETCH, S_WAIT: begin
        if (redirect) begin
          pc_d = redirect_pc;
          if (imem_req && !imem_ack) begin
            state_d     = S_DISCARD;
            hold_addr_d = pc_q;
          end else begin
            state_d = S_FETCH;
          end
        end else if (imem_req) begin
          if (imem_ack) begin
            pc_d    = pc_q + 32'd4;
            state_d = S_FETCH;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_DISCARD: begin
        // A later redirect simply replaces the pending target held in pc.
        if (redirect) begin
          pc_d = redirect_pc;
        end
        if (imem_ack) begin
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // FIFO occupancy: simultaneous push and pop leave the count unchanged.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Control state registers with synchronous reset; redirect flushes the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      hold_addr_q <= RESET_PC;
      count_q     <= 2'd0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      hold_addr_q <= hold_addr_d;
      if (redirect) begin
        count_q  <= 2'd0;
        rd_ptr_q <= 1'b0;
        wr_ptr_q <= 1'b0;
      end else begin
        count_q <= count_d;
        if (push) begin
          wr_ptr_q <= ~wr_ptr_q;
        end
        if (pop) begin
          rd_ptr_q <= ~rd_ptr_q;
        end
      end
    end
  end

  // FIFO storage: payload only, validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr_q[wr_ptr_q] <= imem_rdata;
      fifo_pc_q[wr_ptr_q]    <= pc_q;
    end
  end

  assign instr    = fifo_instr_q[rd_ptr_q];
  assign instr_pc = fifo_pc_q[rd_ptr_q];

  // Field extraction is purely positional; decode interprets them.
  assign cond = instr[31:28];
  assign op   = instr[27:26];
  assign func = instr[25:20];
  assign rd   = instr[15:12];

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q;
  logic [15:0] perf_flushes_q;

  // Performance counters: accepted (not dropped) words and redirects; both wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_q <= 32'd0;
      perf_flushes_q <= 16'd0;
    end else begin
      if (push) begin
        perf_fetched_q <= perf_fetched_q + 32'd1;
      end
      if (redirect) begin
        perf_flushes_q <= perf_flushes_q + 16'd1;
      end
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_flushes = perf_flushes_q;
`endif

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, PC loaded on reset.
REQ-002 clk  input  1  single system clock, all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 imem_req  output  1  instruction memory read request.
REQ-005 imem_addr  output  32  word-aligned fetch address.
REQ-006 imem_ack  input  1  memory accepts request; imem_rdata valid this cycle.
REQ-007 imem_rdata  input  32  fetched instruction word.
REQ-008 redirect  input  1  branch taken (driven from PCSrc).
REQ-009 redirect_pc  input  32  branch target, sampled when redirect=1.
REQ-010 instr_valid  output  1  instruction word presented to decode.
REQ-011 instr_ready  input  1  decode consumes the presented instruction.
REQ-012 instr  output  32  presented instruction word.
REQ-013 instr_pc  output  32  address of presented instruction.
REQ-014 cond/op/func/rd  output  4/2/6/4  fields instr[31:28], [27:26], [25:20], [15:12].

Function
REQ-015 The block SHALL hold a PC register, a 2-entry FIFO of {instr, pc}, and an FSM with states FETCH, WAIT, DISCARD.
REQ-016 FETCH: imem_req=1, imem_addr=PC when FIFO count<2; otherwise imem_req=0.
REQ-017 While imem_req=1 and imem_ack=0, imem_addr SHALL stay stable and FSM SHALL be in WAIT.
REQ-018 On imem_ack without redirect: push {imem_rdata, PC}, PC<=PC+4 (mod 2^32, wraps to 0), return to FETCH.
REQ-019 instr_valid SHALL equal (count>0); instr/instr_pc/fields SHALL come from the FIFO head.
REQ-020 Pop occurs when instr_valid & instr_ready; simultaneous push and pop leaves count unchanged.
REQ-021 Minimum latency: instr_valid rises the cycle after the imem_ack cycle.
REQ-022 redirect has priority over push and pop: FIFO flushed, PC<=redirect_pc, instr_valid=0 next cycle.
REQ-023 redirect with imem_ack in same cycle: returned word dropped, FSM to FETCH.
REQ-024 redirect while request outstanding (no ack): FSM to DISCARD; imem_req/imem_addr held until ack; acked data dropped; then FETCH at redirect_pc.
REQ-025 redirect during DISCARD SHALL overwrite the pending target; last target wins.
REQ-026 Fields SHALL be pure slices of instr; no decoding in this block.

Reset
REQ-027 While rst=1: PC=RESET_PC, FIFO count=0, FSM=FETCH, imem_req=0, instr_valid=0.
REQ-028 First imem_req=1 with imem_addr=RESET_PC SHALL occur the first cycle rst=0.
REQ-029 rst during WAIT/DISCARD SHALL abandon the outstanding request; a late ack SHALL be ignored.

Configuration
REQ-030 Macro FETCH_PERF_CNT_EN defined: adds outputs perf_fetched[31:0] (increments per pushed word) and perf_flushes[15:0] (increments per redirect), both wrap, cleared by rst.
REQ-031 Macro FETCH_PERF_CNT_EN undefined: those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-032 Reset release, imem_ack=1 every cycle, instr_ready=1 -> imem_addr 0,4,8,...; instr_pc follows one cycle after each ack.
REQ-033 instr_ready=0, ack every cycle -> two words buffered, imem_req=0 at count=2; ready=1 resumes with addresses in order, none lost.
REQ-034 Ack delayed 3 cycles -> imem_addr stable for all 4 cycles; instr_valid rises cycle after ack.
REQ-035 Request at 0x10 pending, redirect=1 redirect_pc=0x100, ack 2 cycles later -> word for 0x10 dropped, next imem_addr=0x100, instr_valid stays 0 until 0x100 returns.
REQ-036 PC=0xFFFF_FFFC acked -> next imem_addr=0x0000_0000.
REQ-037 FETCH_PERF_CNT_EN defined, 5 fetches and 2 redirects -> perf_fetched counts dropped words excluded, perf_flushes=2.
